// File: rtl/memarb_pkg.sv
`default_nettype none
// memarb_pkg: owner encoding and defaults shared by the memory arbiter blocks.
// Rev 1.0
package memarb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_DM   = 2'b10
  } owner_t;

  localparam int STARVELIMIT_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/memarbstarve.sv
`default_nettype none
// memarbstarve: counts consecutive denied fetch cycles and flags when fetch must win.
// Rev 1.0
module memarbstarve
  import memarb_pkg::*;
#(
  parameter int STARVELIMIT = STARVELIMIT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic req,
  input  logic gnt,
  output logic limit
);

  localparam int CW = (STARVELIMIT < 2) ? 1 : $clog2(STARVELIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVELIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (req & ~gnt) begin
      if (cnt != LIM) cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  // A zero limit keeps the counter pinned at zero and never raises the flag.
  assign limit = (STARVELIMIT != 0) && (cnt == LIM);

endmodule
`default_nettype wire

// File: rtl/memarbiter.sv
`default_nettype none
// memarbiter: single-port sram arbiter for fetch and data ports, data-first with fetch starvation override.
// Optional MEMARB_STATS_EN adds saturating stall counters. Rev 1.0
module memarbiter
  import memarb_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int STARVELIMIT = STARVELIMIT_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ifreq,
  input  logic [AWIDTH-1:0] ifaddr,
  output logic              ifgnt,
  output logic              ifstall,
  output logic              ifvalid,
  output logic [DWIDTH-1:0] ifdata,
  input  logic              dmrd,
  input  logic              dmwr,
  input  logic [AWIDTH-1:0] dmaddr,
  input  logic [DWIDTH-1:0] dmdin,
  output logic              dmgnt,
  output logic              dmvalid,
  output logic [DWIDTH-1:0] dmdout,
  output logic [AWIDTH-1:0] memaddr,
  output logic              memrd,
  output logic              memwr,
  output logic              memcs,
  output logic [DWIDTH-1:0] memdin,
  input  logic [DWIDTH-1:0] memdout
`ifdef MEMARB_STATS_EN
  ,
  output logic [31:0]       ifstallcnt,
  output logic [31:0]       dmstallcnt
`endif
);

  owner_t pend, pend_nxt;
  logic   dmreq;
  logic   starve_limit;
  logic   dmwrite;

  assign dmreq = dmrd | dmwr;

  memarbstarve #(
    .STARVELIMIT(STARVELIMIT)
  ) u_starve (
    .clk  (clk),
    .clr  (clr),
    .req  (ifreq),
    .gnt  (ifgnt),
    .limit(starve_limit)
  );

  // Grants are gated by clr so the sram sees no access while reset is held.
  assign ifgnt   = clr & ifreq & (~dmreq | starve_limit);
  assign dmgnt   = clr & dmreq & ~(ifreq & starve_limit);
  assign ifstall = clr & ifreq & ~ifgnt;
  assign dmwrite = dmgnt & dmwr;

  assign memcs   = ifgnt | dmgnt;
  assign memrd   = ifgnt | (dmgnt & ~dmwr);
  assign memwr   = dmwrite;
  assign memaddr = ifgnt ? ifaddr : (dmgnt ? dmaddr : '0);
  assign memdin  = dmwrite ? dmdin : '0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) pend <= OWN_NONE;
    else      pend <= pend_nxt;
  end

  always_comb begin
    pend_nxt = OWN_NONE;
    if (ifgnt)                pend_nxt = OWN_IF;
    else if (dmgnt & ~dmwr)   pend_nxt = OWN_DM;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ifvalid <= 1'b0;
      dmvalid <= 1'b0;
      ifdata  <= '0;
      dmdout  <= '0;
    end else begin
      ifvalid <= (pend == OWN_IF);
      dmvalid <= (pend == OWN_DM);
      if (pend == OWN_IF) ifdata <= memdout;
      if (pend == OWN_DM) dmdout <= memdout;
    end
  end

`ifdef MEMARB_STATS_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ifstallcnt <= '0;
      dmstallcnt <= '0;
    end else begin
      if (ifstall && (ifstallcnt != '1))               ifstallcnt <= ifstallcnt + 32'd1;
      if (dmreq && !dmgnt && (dmstallcnt != '1))       dmstallcnt <= dmstallcnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_memarbiter.sv
`default_nettype none
// tb_memarbiter: directed and randomized checks of memarbiter against a cycle-level reference model.
// Rev 1.0
module tb_memarbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        ifreq;
  logic [31:0] ifaddr;
  logic        ifgnt, ifstall, ifvalid;
  logic [31:0] ifdata;
  logic        dmrd, dmwr;
  logic [31:0] dmaddr, dmdin;
  logic        dmgnt, dmvalid;
  logic [31:0] dmdout;
  logic [31:0] memaddr;
  logic        memrd, memwr, memcs;
  logic [31:0] memdin;
  logic [31:0] memdout;
`ifdef MEMARB_STATS_EN
  logic [31:0] ifstallcnt, dmstallcnt;
`endif

  memarbiter #(.AWIDTH(32), .DWIDTH(32), .STARVELIMIT(LIM)) dut (
    .clk(clk), .clr(clr),
    .ifreq(ifreq), .ifaddr(ifaddr), .ifgnt(ifgnt), .ifstall(ifstall),
    .ifvalid(ifvalid), .ifdata(ifdata),
    .dmrd(dmrd), .dmwr(dmwr), .dmaddr(dmaddr), .dmdin(dmdin),
    .dmgnt(dmgnt), .dmvalid(dmvalid), .dmdout(dmdout),
    .memaddr(memaddr), .memrd(memrd), .memwr(memwr), .memcs(memcs),
    .memdin(memdin), .memdout(memdout)
`ifdef MEMARB_STATS_EN
    , .ifstallcnt(ifstallcnt), .dmstallcnt(dmstallcnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)  return 32'h8C220004;
    if (i == 64) return 32'hDEADBEEF;
    return i * 32'h9E3779B1;
  endfunction

  // Synchronous sram behind the arbiter: read data appears the cycle after the access.
  logic [31:0] sram [256];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (memcs) begin
      if (memwr) sram[memaddr[9:2]] <= memdin;
      if (memrd) memdout <= sram[memaddr[9:2]];
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h required %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [256];
  int          starve = 0;
  bit          p1_v = 0, p1_is_if = 0;
  logic [31:0] p1_d = '0;
  bit          e_ifv = 0, e_dmv = 0;
  logic [31:0] e_ifd = '0, e_dmd = '0;
  bit          g_if = 0, g_dm = 0;
  longint      if_sc = 0, dm_sc = 0;

  task automatic run_cycle();
    bit          dreq, lim, eif, edm, ewr, erd;
    logic [31:0] eaddr, edin;
    #1;
    if (!clr) begin
      starve = 0; p1_v = 0; e_ifv = 0; e_dmv = 0; e_ifd = '0; e_dmd = '0;
      if_sc = 0; dm_sc = 0;
    end
    dreq  = dmrd | dmwr;
    lim   = (LIM != 0) && (starve == LIM);
    eif   = clr && ifreq && (!dreq || lim);
    edm   = clr && dreq && !eif;
    ewr   = edm && dmwr;
    erd   = eif || (edm && !dmwr);
    eaddr = eif ? ifaddr : (edm ? dmaddr : 32'h0);
    edin  = ewr ? dmdin : 32'h0;

    check_eq("ifgnt",   64'(ifgnt),   64'(eif));
    check_eq("dmgnt",   64'(dmgnt),   64'(edm));
    check_eq("ifstall", 64'(ifstall), 64'(clr && ifreq && !eif));
    check_eq("memcs",   64'(memcs),   64'(eif || edm));
    check_eq("memrd",   64'(memrd),   64'(erd));
    check_eq("memwr",   64'(memwr),   64'(ewr));
    check_eq("memaddr", 64'(memaddr), 64'(eaddr));
    check_eq("memdin",  64'(memdin),  64'(edin));
    check_eq("ifvalid", 64'(ifvalid), 64'(e_ifv));
    check_eq("dmvalid", 64'(dmvalid), 64'(e_dmv));
    check_eq("ifdata",  64'(ifdata),  64'(e_ifd));
    check_eq("dmdout",  64'(dmdout),  64'(e_dmd));
`ifdef MEMARB_STATS_EN
    check_eq("ifstallcnt", 64'(ifstallcnt), 64'(if_sc));
    check_eq("dmstallcnt", 64'(dmstallcnt), 64'(dm_sc));
`endif

    if (clr) begin
      e_ifv = p1_v && p1_is_if;
      e_dmv = p1_v && !p1_is_if;
      if (e_ifv) e_ifd = p1_d;
      if (e_dmv) e_dmd = p1_d;
      p1_v     = erd;
      p1_is_if = eif;
      p1_d     = ref_mem[eaddr[9:2]];
      if (ewr) ref_mem[dmaddr[9:2]] = dmdin;
      if (ifreq && !eif) starve = (starve < LIM) ? starve + 1 : LIM;
      else               starve = 0;
      if (ifreq && !eif) if_sc++;
      if (dreq && !edm)  dm_sc++;
    end
    g_if = eif;
    g_dm = edm;
    @(negedge clk);
  endtask

  task automatic set_in(input bit ir, input logic [31:0] ia, input bit rd, input bit wr,
                        input logic [31:0] da, input logic [31:0] dd);
    ifreq = ir; ifaddr = ia; dmrd = rd; dmwr = wr; dmaddr = da; dmdin = dd;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0);
    repeat (n) run_cycle();
  endtask

  initial begin
    clr = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    @(negedge clk);

    // Reset holds off requests; data wins in the first cycle after release.
    set_in(1, 32'h10, 1, 0, 32'h100, 0);
    run_cycle(); run_cycle();
    clr = 1'b1;
    run_cycle();
    set_in(1, 32'h10, 0, 0, 0, 0);
    run_cycle();
    idle(3);

    // Lone fetch
    set_in(1, 32'h10, 0, 0, 0, 0);
    run_cycle();
    idle(4);

    // Contention
    set_in(1, 32'h10, 1, 0, 32'h100, 0);
    run_cycle();
    set_in(1, 32'h10, 0, 0, 0, 0);
    run_cycle();
    idle(4);

    // Starvation override
    set_in(1, 32'h14, 0, 1, 32'h300, 32'hA5A5A5A5);
    repeat (6) run_cycle();
    idle(3);

    // Read+write together behaves as a write, then read it back
    set_in(0, 0, 1, 1, 32'h200, 32'h12345678);
    run_cycle();
    set_in(0, 0, 1, 0, 32'h200, 0);
    run_cycle();
    idle(4);

    // Reset while a fetch is in flight
    set_in(1, 32'h10, 0, 0, 0, 0);
    run_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    clr = 1'b0;
    run_cycle(); run_cycle();
    clr = 1'b1;
    run_cycle(); run_cycle(); run_cycle();

    // Randomized traffic; requests stay held until granted.
    for (int c = 0; c < 2000; c++) begin
      if (!(ifreq && !g_if)) begin
        ifreq  = ($urandom % 3) != 0;
        ifaddr = $urandom;
      end
      if (!((dmrd | dmwr) && !g_dm)) begin
        int k;
        k      = $urandom % 4;
        dmrd   = k[0];
        dmwr   = k[1];
        dmaddr = $urandom;
        dmdin  = $urandom;
      end
      clr = ($urandom % 150) != 0;
      run_cycle();
    end
    clr = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memarbiter.md
# memarbiter

Arbiter and sequencer for one single-ported `sram` shared by the pipeline's instruction-fetch (IF) port and data-memory (MEM) port. It sits between the IF stage, the MEM stage and the shared memory instance.
- Grants one access per cycle, with data-over-fetch priority and a bounded fetch-starvation override.
- Tracks which port owns the outstanding synchronous read and returns registered read data to that port.
- Drives `ifstall` toward the hazard logic that controls PC `en1`.

## Interface
Parameters:
- AWIDTH, 32, address width of both ports and the memory
- DWIDTH, 32, data width
- STARVELIMIT, 4, consecutive denied fetch cycles before fetch wins one cycle; 0 disables the override

Ports:
- clk  in  1  single clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- ifreq  in  1  fetch read request, held until granted
- ifaddr  in  AWIDTH  fetch byte address
- ifgnt  out  1  fetch granted this cycle (combinational)
- ifstall  out  1  ifreq & ~ifgnt
- ifvalid  out  1  ifdata valid, one-cycle pulse
- ifdata  out  DWIDTH  fetched instruction (registered)
- dmrd  in  1  data read request, held until granted
- dmwr  in  1  data write request, held until granted
- dmaddr  in  AWIDTH  data byte address
- dmdin  in  DWIDTH  write data
- dmgnt  out  1  data access granted this cycle (combinational)
- dmvalid  out  1  dmdout valid, one-cycle pulse
- dmdout  out  DWIDTH  load data (registered)
- memaddr  out  AWIDTH  to sram address
- memrd  out  1  to sram rd
- memwr  out  1  to sram wr
- memcs  out  1  to sram cs
- memdin  out  DWIDTH  to sram din
- memdout  in  DWIDTH  from sram dout, valid the cycle after the read is issued

## Operation
- Owner FSM `pend`, updated every edge from the current grant:
  - OWN_NONE: no read in flight.
  - OWN_IF: a fetch read was issued last cycle.
  - OWN_DM: a load was issued last cycle.
- Transitions:
  - Fetch grant → OWN_IF.
  - Load grant → OWN_DM.
  - Write grant or no grant → OWN_NONE.
- Grant selection, evaluated every cycle independently of `pend` (back-to-back issue allowed):
  - Data request (dmrd | dmwr) wins over ifreq.
  - Exception: if starvecnt == STARVELIMIT and STARVELIMIT ≠ 0, fetch wins and dmgnt = 0.
- starvecnt:
  - Increments on ifreq & ~ifgnt and saturates at STARVELIMIT.
  - Clears on ifgnt, or when ifreq = 0.
- Memory-side drive on a granted access:
  - memcs = 1.
  - memaddr = address of the granted port, passed through unmodified including bits [1:0].
  - Load/fetch: memrd = 1, memwr = 0.
  - Write: memwr = 1, memrd = 0, memdin = dmdin.
- No grant: memcs, memrd, memwr = 0; memaddr and memdin = 0.
- dmrd & dmwr asserted together: treated as a write only; no dmvalid.
- Read return:
  - pend = OWN_IF: ifdata <= memdout, ifvalid <= 1.
  - pend = OWN_DM: dmdout <= memdout, dmvalid <= 1.
  - Valids are otherwise 0. Data registers hold their last value.
- Writes produce no response.

## Timing
- Request to grant: 0 cycles when the port wins. Sram inputs are driven in the grant cycle.
- Grant in cycle N → memdout valid in N+1 → ifvalid/dmvalid = 1 in N+2 with data. Read latency is 2.
- Throughput: one access per cycle. Up to two reads can be in flight (pend plus the output register).
- Reset while clr = 0, forced regardless of the clock:
  - pend = OWN_NONE, starvecnt = 0.
  - ifvalid, dmvalid = 0; ifdata, dmdout = 0.
  - ifgnt, dmgnt, memcs, memrd, memwr = 0; ifstall = 0.
- Reset mid-read: the in-flight response is discarded and no valid pulse follows release.
- The first grant is possible in the first cycle with clr = 1.

## Configuration
- `MEMARB_STATS_EN` defined: adds outputs `ifstallcnt` and `dmstallcnt` (out, 32).
  - `ifstallcnt` counts cycles with ifreq & ~ifgnt.
  - `dmstallcnt` counts cycles with (dmrd | dmwr) & ~dmgnt.
  - Both are saturating at 32'hFFFFFFFF and reset to 0 by clr.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- Shared package `memarb_pkg`:
  - Owner encoding: OWN_NONE = 2'b00, OWN_IF = 2'b01, OWN_DM = 2'b10.
  - Default STARVELIMIT.
- One sub-module, `memarbstarve`: starvation counter with saturate/clear and a `limit` flag output, parameterised by STARVELIMIT.
- Grant logic, memory mux and return registers stay in `memarbiter`.

## Test plan
- Reset: clr = 0 with ifreq = 1 and dmrd = 1 → ifgnt = dmgnt = memcs = 0 and all valids 0. After release, dmgnt = 1 in the first cycle.
- Lone fetch: ifaddr = 0x10, memory word 0x8C220004, grant in cycle 0 → ifvalid = 1 in cycle 2 with ifdata = 0x8C220004, pulse width 1.
- Contention: ifreq with dmrd at 0x100 (word 0xDEADBEEF):
  - cycle 0: dmgnt = 1, ifstall = 1.
  - cycle 1: ifgnt = 1.
  - cycle 2: dmvalid = 1, dmdout = 0xDEADBEEF.
  - cycle 3: ifvalid = 1.
- Starvation: dmwr and ifreq held for 6 cycles, STARVELIMIT = 4 → ifgnt = 1 in cycle 4 only, dmgnt = 0 in cycle 4, and starvecnt returns to 0.
- Simultaneous dmrd & dmwr at 0x200 with dmdin = 0x12345678 → memwr = 1, memrd = 0, no dmvalid. A subsequent load of 0x200 returns 0x12345678.
- Reset mid-read: fetch granted in cycle 0, clr = 0 in cycle 1 → ifvalid never asserts and ifdata = 0.
